// File: rtl/kmu_cta_dispatcher.sv
// Kernel-management CTA dispatcher.
// Kernel configuration arrives as DCR writes into shadow registers. A launch
// handshake snapshots the shadow registers into an active copy. The 3-D grid
// is then walked with z fastest, then y, then x, and one CTA is issued per
// cycle to a round-robin selected ready core. CTA completions are counted,
// and a done pulse is raised once every issued CTA has completed.
module kmu_cta_dispatcher #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned DCR_ADDR_W  = 12,
  parameter int unsigned DCR_DATA_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dcr_wr_valid,
  input  logic [DCR_ADDR_W-1:0] dcr_wr_addr,
  input  logic [DCR_DATA_W-1:0] dcr_wr_data,
  input  logic                  launch_valid,
  output logic                  launch_ready,
  output logic                  task_valid,
  input  logic [NUM_CORES-1:0]  task_ready,
  output logic [NUM_CORES-1:0]  task_grant,
  output logic [31:0]           task_pc,
  output logic [31:0]           task_param,
  output logic [31:0]           task_num_warps,
  output logic [31:0]           task_cta_x,
  output logic [31:0]           task_cta_y,
  output logic [31:0]           task_cta_z,
  output logic [31:0]           task_cta_id,
  input  logic [NUM_CORES-1:0]  cta_done,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [DCR_ADDR_W-1:0] VX_DCR_BASE_STARTUP_ADDR0 = DCR_ADDR_W'(32'h001);
  localparam logic [DCR_ADDR_W-1:0] VX_DCR_BASE_STARTUP_ARG0  = DCR_ADDR_W'(32'h003);
  localparam logic [DCR_ADDR_W-1:0] VX_DCR_KMU_GRID_DIM0      = DCR_ADDR_W'(32'h006);
  localparam logic [DCR_ADDR_W-1:0] VX_DCR_KMU_GRID_DIM1      = DCR_ADDR_W'(32'h007);
  localparam logic [DCR_ADDR_W-1:0] VX_DCR_KMU_GRID_DIM2      = DCR_ADDR_W'(32'h008);
  localparam logic [DCR_ADDR_W-1:0] VX_DCR_KMU_BLOCK_DIM0     = DCR_ADDR_W'(32'h009);
  localparam logic [DCR_ADDR_W-1:0] VX_DCR_KMU_BLOCK_DIM1     = DCR_ADDR_W'(32'h00A);
  localparam logic [DCR_ADDR_W-1:0] VX_DCR_KMU_BLOCK_DIM2     = DCR_ADDR_W'(32'h00B);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  // shadow (DCR-written) configuration
  logic [31:0] sh_pc, sh_arg, sh_gx, sh_gy, sh_gz, sh_bx, sh_by, sh_bz;
  // active configuration for the running kernel
  logic [31:0] act_pc, act_arg, act_gx, act_gy, act_gz, num_warps;
  // grid walk position and counters
  logic [31:0] cx, cy, cz, cid, issued, completed;
  logic [31:0] nx, ny, nz;
  logic        is_last;

  logic [PTR_W-1:0] rr_ptr, rr_next, grant_idx;
  logic             found;
  int unsigned      cand;

  logic        launch_fire, dispatch_fire, grid_zero, count_en;
  logic [31:0] bx1, by1, bz1, blk_prod, warps_calc, done_cnt, completed_sum;
  logic [32:0] warps_wide;

  assign launch_fire   = launch_valid && (state == S_IDLE);
  assign grid_zero     = (sh_gx == '0) || (sh_gy == '0) || (sh_gz == '0);
  assign count_en      = (state == S_DISPATCH) || (state == S_DRAIN);
  assign dispatch_fire = (state == S_DISPATCH) && found;

  assign launch_ready   = (state == S_IDLE);
  assign task_valid     = (state == S_DISPATCH);
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign task_pc        = act_pc;
  assign task_param     = act_arg;
  assign task_num_warps = num_warps;
  assign task_cta_x     = cx;
  assign task_cta_y     = cy;
  assign task_cta_z     = cz;
  assign task_cta_id    = cid;

  // Capture DCR writes into the shadow configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_pc  <= '0;
      sh_arg <= '0;
      sh_gx  <= '0;
      sh_gy  <= '0;
      sh_gz  <= '0;
      sh_bx  <= '0;
      sh_by  <= '0;
      sh_bz  <= '0;
    end else if (dcr_wr_valid) begin
      case (dcr_wr_addr)
        VX_DCR_BASE_STARTUP_ADDR0: sh_pc  <= 32'(dcr_wr_data);
        VX_DCR_BASE_STARTUP_ARG0:  sh_arg <= 32'(dcr_wr_data);
        VX_DCR_KMU_GRID_DIM0:      sh_gx  <= 32'(dcr_wr_data);
        VX_DCR_KMU_GRID_DIM1:      sh_gy  <= 32'(dcr_wr_data);
        VX_DCR_KMU_GRID_DIM2:      sh_gz  <= 32'(dcr_wr_data);
        VX_DCR_KMU_BLOCK_DIM0:     sh_bx  <= 32'(dcr_wr_data);
        VX_DCR_KMU_BLOCK_DIM1:     sh_by  <= 32'(dcr_wr_data);
        VX_DCR_KMU_BLOCK_DIM2:     sh_bz  <= 32'(dcr_wr_data);
        default: ;
      endcase
    end
  end

  // Warps per CTA: ceil(block volume / NUM_THREADS), zero dims treated as 1.
  always_comb begin
    bx1        = (sh_bx == '0) ? 32'd1 : sh_bx;
    by1        = (sh_by == '0) ? 32'd1 : sh_by;
    bz1        = (sh_bz == '0) ? 32'd1 : sh_bz;
    blk_prod   = bx1 * by1 * bz1;
    warps_wide = ({1'b0, blk_prod} + 33'(NUM_THREADS - 1)) / 33'(NUM_THREADS);
    warps_calc = warps_wide[31:0];
  end

  // Round-robin pick: first ready core at or after rr_ptr, wrapping around.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!found && task_ready[cand[PTR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  // One-hot grant and the pointer value following the granted core.
  always_comb begin
    task_grant = '0;
    if (dispatch_fire) task_grant[grant_idx] = 1'b1;
    if (32'(grant_idx) == NUM_CORES - 1) rr_next = '0;
    else                                 rr_next = grant_idx + PTR_W'(1);
  end

  // Completion popcount for this cycle.
  always_comb begin
    done_cnt = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + 32'(cta_done[i]);
    end
    completed_sum = completed + done_cnt;
  end

  // Next grid position, z fastest, then y, then x.
  always_comb begin
    nx      = cx;
    ny      = cy;
    nz      = cz;
    is_last = (cx == act_gx - 32'd1) && (cy == act_gy - 32'd1) && (cz == act_gz - 32'd1);
    if (cz == act_gz - 32'd1) begin
      nz = '0;
      if (cy == act_gy - 32'd1) begin
        ny = '0;
        nx = cx + 32'd1;
      end else begin
        ny = cy + 32'd1;
      end
    end else begin
      nz = cz + 32'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // DRAIN compares against the count including this cycle's pulses, so done
  // follows the final completion pulse by exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (launch_fire) state_next = grid_zero ? S_DONE : S_DISPATCH;
      S_DISPATCH: if (dispatch_fire && is_last) state_next = S_DRAIN;
      S_DRAIN:    if (completed_sum == issued) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Kernel snapshot, grid walk and issue/completion counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_pc    <= '0;
      act_arg   <= '0;
      act_gx    <= '0;
      act_gy    <= '0;
      act_gz    <= '0;
      num_warps <= '0;
      cx        <= '0;
      cy        <= '0;
      cz        <= '0;
      cid       <= '0;
      issued    <= '0;
      completed <= '0;
    end else if (launch_fire) begin
      act_pc    <= sh_pc;
      act_arg   <= sh_arg;
      act_gx    <= sh_gx;
      act_gy    <= sh_gy;
      act_gz    <= sh_gz;
      num_warps <= warps_calc;
      cx        <= '0;
      cy        <= '0;
      cz        <= '0;
      cid       <= '0;
      issued    <= '0;
      completed <= '0;
    end else begin
      if (dispatch_fire) begin
        cx     <= nx;
        cy     <= ny;
        cz     <= nz;
        cid    <= cid + 32'd1;
        issued <= issued + 32'd1;
      end
      if (count_en) completed <= completed_sum;
    end
  end

  // Round-robin pointer advances past each granted core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              rr_ptr <= '0;
    else if (dispatch_fire) rr_ptr <= rr_next;
  end

endmodule

// File: tb/tb_kmu_cta_dispatcher.sv
// Scoreboard bench for kmu_cta_dispatcher: expected CTAs are queued when a
// kernel is launched and popped by a monitor whenever a CTA is granted.
module tb_kmu_cta_dispatcher;

  localparam int NC = 4;

  localparam logic [11:0] A_PC  = 12'h001;
  localparam logic [11:0] A_ARG = 12'h003;
  localparam logic [11:0] A_GX  = 12'h006;
  localparam logic [11:0] A_GY  = 12'h007;
  localparam logic [11:0] A_GZ  = 12'h008;
  localparam logic [11:0] A_BX  = 12'h009;
  localparam logic [11:0] A_BY  = 12'h00A;
  localparam logic [11:0] A_BZ  = 12'h00B;

  logic          clk = 1'b0;
  logic          reset;
  logic          dcr_wr_valid;
  logic [11:0]   dcr_wr_addr;
  logic [31:0]   dcr_wr_data;
  logic          launch_valid;
  logic          launch_ready;
  logic          task_valid;
  logic [NC-1:0] task_ready;
  logic [NC-1:0] task_grant;
  logic [31:0]   task_pc, task_param, task_num_warps;
  logic [31:0]   task_cta_x, task_cta_y, task_cta_z, task_cta_id;
  logic [NC-1:0] cta_done;
  logic          busy;
  logic          done;

  typedef struct {
    logic [31:0]   x, y, z, id, warps, pc, param;
    logic [NC-1:0] grant;
  } cta_t;

  cta_t exp_q[$];
  cta_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  kmu_cta_dispatcher #(
    .NUM_CORES(NC),
    .NUM_THREADS(4),
    .DCR_ADDR_W(12),
    .DCR_DATA_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dcr_wr_valid(dcr_wr_valid),
    .dcr_wr_addr(dcr_wr_addr),
    .dcr_wr_data(dcr_wr_data),
    .launch_valid(launch_valid),
    .launch_ready(launch_ready),
    .task_valid(task_valid),
    .task_ready(task_ready),
    .task_grant(task_grant),
    .task_pc(task_pc),
    .task_param(task_param),
    .task_num_warps(task_num_warps),
    .task_cta_x(task_cta_x),
    .task_cta_y(task_cta_y),
    .task_cta_z(task_cta_z),
    .task_cta_id(task_cta_id),
    .cta_done(cta_done),
    .busy(busy),
    .done(done)
  );

  // Monitor: every granted CTA must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && task_valid && task_grant != '0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_cta: got id %0d grant %b, required no CTA", task_cta_id, task_grant);
      end else begin
        mon_e = exp_q.pop_front();
        if ({task_cta_x, task_cta_y, task_cta_z, task_cta_id} !== {mon_e.x, mon_e.y, mon_e.z, mon_e.id}) begin
          miscompares++;
          $display("FAIL cta_coord: got (%0d,%0d,%0d) id %0d, required (%0d,%0d,%0d) id %0d",
                   task_cta_x, task_cta_y, task_cta_z, task_cta_id, mon_e.x, mon_e.y, mon_e.z, mon_e.id);
        end
        vectors++;
        if (task_grant !== mon_e.grant) begin
          miscompares++;
          $display("FAIL cta_grant: id %0d got %b, required %b", mon_e.id, task_grant, mon_e.grant);
        end
        vectors++;
        if ({task_num_warps, task_pc, task_param} !== {mon_e.warps, mon_e.pc, mon_e.param}) begin
          miscompares++;
          $display("FAIL cta_payload: id %0d got warps %0d pc %h arg %h, required warps %0d pc %h arg %h",
                   mon_e.id, task_num_warps, task_pc, task_param, mon_e.warps, mon_e.pc, mon_e.param);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    dcr_wr_valid = 1'b0;
    dcr_wr_addr  = '0;
    dcr_wr_data  = '0;
    launch_valid = 1'b0;
    task_ready   = '0;
    cta_done     = '0;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic dcr_write(input logic [11:0] a, input logic [31:0] d);
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = a;
    dcr_wr_data  = d;
    step();
    dcr_wr_valid = 1'b0;
  endtask

  task automatic configure(input logic [31:0] gx, gy, gz, bx, by, bz, pc, arg);
    dcr_write(A_PC, pc);
    dcr_write(A_ARG, arg);
    dcr_write(12'h0FF, 32'hDEAD_BEEF);  // unmapped address, must be ignored
    dcr_write(A_GX, gx);
    dcr_write(A_GY, gy);
    dcr_write(A_GZ, gz);
    dcr_write(A_BX, bx);
    dcr_write(A_BY, by);
    dcr_write(A_BZ, bz);
  endtask

  task automatic push_one(input int x, y, z, id, input logic [31:0] warps, pc, arg, input logic [NC-1:0] g);
    cta_t e;
    e.x = 32'(x); e.y = 32'(y); e.z = 32'(z); e.id = 32'(id);
    e.warps = warps; e.pc = pc; e.param = arg; e.grant = g;
    exp_q.push_back(e);
  endtask

  // Expected CTAs with every core ready, round robin starting at rr0.
  task automatic push_grid(input int gx, gy, gz, input logic [31:0] warps, pc, arg, input int rr0);
    int id = 0;
    for (int x = 0; x < gx; x++)
      for (int y = 0; y < gy; y++)
        for (int z = 0; z < gz; z++) begin
          push_one(x, y, z, id, warps, pc, arg, NC'(1 << ((rr0 + id) % NC)));
          id++;
        end
  endtask

  task automatic launch();
    vectors++;
    if (launch_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL launch_ready_idle: got %b, required 1", launch_ready);
    end
    launch_valid = 1'b1;
    step();
    launch_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      step();
      cycles++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL dispatch_timeout: got %0d CTAs outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic finish_kernel(input logic [NC-1:0] p1, input logic [NC-1:0] p2);
    cta_done = p1;
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_early: got %b, required 0", done);
    end
    cta_done = p2;
    step();
    cta_done = '0;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_pulse: got %b, required 1", done);
    end
    step();
    vectors++;
    if ({done, launch_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL done_return_idle: got done/ready/busy %b, required 010", {done, launch_ready, busy});
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({launch_ready, task_valid, busy, done, task_grant} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready/valid/busy/done/grant %b, required 1000_0000",
               {launch_ready, task_valid, busy, done, task_grant});
    end
    vectors++;
    if ({task_pc, task_param, task_num_warps, task_cta_x, task_cta_y, task_cta_z, task_cta_id} !== '0) begin
      miscompares++;
      $display("FAIL reset_payload: got pc %h arg %h warps %0d id %0d, required all 0",
               task_pc, task_param, task_num_warps, task_cta_id);
    end
  endtask

  task automatic test_grid_walk();
    int cyc;
    do_reset();
    configure(2, 1, 3, 8, 1, 1, 32'h8000_0000, 32'h1234_5678);
    push_grid(2, 1, 3, 2, 32'h8000_0000, 32'h1234_5678, 0);
    task_ready = 4'b1111;
    launch();
    vectors++;
    if ({task_valid, task_cta_id, busy, launch_ready} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL launch_latency: got valid %b id %0d busy %b ready %b, required 1 0 1 0",
               task_valid, task_cta_id, busy, launch_ready);
    end
    wait_drain(20, cyc);
    vectors++;
    if (cyc !== 6) begin
      miscompares++;
      $display("FAIL back_to_back: got %0d cycles for 6 CTAs, required 6", cyc);
    end
    vectors++;
    if ({task_valid, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL drain_state: got valid/busy %b, required 01", {task_valid, busy});
    end
    task_ready = '0;
    finish_kernel(4'b1111, 4'b0011);
  endtask

  task automatic test_round_robin();
    int cyc;
    do_reset();
    configure(1, 1, 3, 4, 1, 1, 32'h0000_1000, 32'h0000_2000);
    push_one(0, 0, 0, 0, 1, 32'h0000_1000, 32'h0000_2000, 4'b0100);
    push_one(0, 0, 1, 1, 1, 32'h0000_1000, 32'h0000_2000, 4'b1000);
    push_one(0, 0, 2, 2, 1, 32'h0000_1000, 32'h0000_2000, 4'b0001);
    task_ready = '0;
    launch();
    vectors++;
    if ({task_valid, task_grant, task_cta_id} !== {1'b1, 4'b0000, 32'd0}) begin
      miscompares++;
      $display("FAIL stall_no_grant: got valid %b grant %b id %0d, required 1 0000 0",
               task_valid, task_grant, task_cta_id);
    end
    step();
    vectors++;
    if ({task_valid, task_cta_id} !== {1'b1, 32'd0}) begin
      miscompares++;
      $display("FAIL stall_hold: got valid %b id %0d, required 1 0", task_valid, task_cta_id);
    end
    task_ready = 4'b0100;
    step();
    task_ready = 4'b1001;
    wait_drain(5, cyc);
    task_ready = '0;
    vectors++;
    if (task_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_drain: got valid %b, required 0", task_valid);
    end
    finish_kernel(4'b0011, 4'b0100);
  endtask

  task automatic test_num_warps();
    int cyc;
    do_reset();
    task_ready = 4'b1111;
    configure(1, 1, 1, 0, 0, 5, 32'hA, 32'hB);
    push_grid(1, 1, 1, 2, 32'hA, 32'hB, 0);
    launch();
    wait_drain(5, cyc);
    finish_kernel(4'b0000, 4'b0001);
    configure(1, 1, 1, 3, 3, 1, 32'hC, 32'hD);
    push_grid(1, 1, 1, 3, 32'hC, 32'hD, 1);
    launch();
    wait_drain(5, cyc);
    finish_kernel(4'b0000, 4'b0010);
    // volume 65536*65537 wraps to 65536 in 32 bits
    configure(1, 1, 1, 65536, 65537, 1, 32'hE, 32'hF);
    push_grid(1, 1, 1, 16384, 32'hE, 32'hF, 2);
    launch();
    wait_drain(5, cyc);
    finish_kernel(4'b0000, 4'b0100);
    task_ready = '0;
  endtask

  task automatic test_zero_grid();
    do_reset();
    task_ready = 4'b1111;
    configure(3, 0, 2, 4, 1, 1, 32'h10, 32'h20);
    launch();
    vectors++;
    if ({task_valid, done, busy} !== 3'b011) begin
      miscompares++;
      $display("FAIL zero_grid_done: got valid/done/busy %b, required 011", {task_valid, done, busy});
    end
    step();
    vectors++;
    if ({task_valid, done, launch_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL zero_grid_idle: got valid/done/ready %b, required 001", {task_valid, done, launch_ready});
    end
    task_ready = '0;
  endtask

  task automatic test_drain();
    int cyc;
    do_reset();
    task_ready = 4'b1111;
    configure(1, 2, 2, 4, 1, 1, 32'h300, 32'h400);
    push_grid(1, 2, 2, 1, 32'h300, 32'h400, 0);
    launch();
    wait_drain(10, cyc);
    task_ready = '0;
    // launch requested while draining must be ignored
    launch_valid = 1'b1;
    cta_done = 4'b1011;
    step();
    launch_valid = 1'b0;
    vectors++;
    if ({done, busy, task_valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL drain_partial: got done/busy/valid %b, required 010", {done, busy, task_valid});
    end
    cta_done = 4'b0100;
    step();
    cta_done = '0;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_done: got %b, required 1", done);
    end
    step();
    vectors++;
    if ({done, launch_ready, task_valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL drain_idle: got done/ready/valid %b, required 010", {done, launch_ready, task_valid});
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    task_ready = 4'b1111;
    configure(2, 2, 2, 8, 8, 1, 32'h500, 32'h600);
    push_grid(1, 1, 2, 16, 32'h500, 32'h600, 0);
    launch();
    step();
    step();
    task_ready = '0;
    vectors++;
    if ({task_valid, task_cta_id} !== {1'b1, 32'd2}) begin
      miscompares++;
      $display("FAIL mid_kernel: got valid %b id %0d, required 1 2", task_valid, task_cta_id);
    end
    reset = 1'b1;
    step();
    vectors++;
    if ({task_valid, busy, done, task_grant, launch_ready} !== {1'b0, 1'b0, 1'b0, 4'b0000, 1'b1}) begin
      miscompares++;
      $display("FAIL abort_ctrl: got valid/busy/done/grant/ready %b, required 0000001",
               {task_valid, busy, done, task_grant, launch_ready});
    end
    vectors++;
    if ({task_cta_id, task_cta_z, task_pc, task_num_warps} !== '0) begin
      miscompares++;
      $display("FAIL abort_payload: got id %0d z %0d pc %h warps %0d, required all 0",
               task_cta_id, task_cta_z, task_pc, task_num_warps);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %b, required 0", done);
    end
    configure(1, 1, 2, 4, 1, 1, 32'h700, 32'h800);
    push_grid(1, 1, 2, 1, 32'h700, 32'h800, 0);
    task_ready = 4'b1111;
    launch();
    vectors++;
    if ({task_valid, task_cta_id} !== {1'b1, 32'd0}) begin
      miscompares++;
      $display("FAIL relaunch_id: got valid %b id %0d, required 1 0", task_valid, task_cta_id);
    end
    wait_drain(10, cyc);
    task_ready = '0;
    finish_kernel(4'b0001, 4'b0010);
  endtask

  initial begin
    test_reset();
    test_grid_walk();
    test_round_robin();
    test_num_warps();
    test_zero_grid();
    test_drain();
    test_reset_mid();
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
